// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - safety observer for traffic_light_controller outputs (optional TLM_COUNT_CHECK_EN countdown check)
module traffic_light_monitor #(
    parameter int MAX_PHASE_CYCLES = 1000,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       street_a,
    input  logic [2:0]       street_b,
    input  logic [6:0]       hex0,
    input  logic [6:0]       hex1,
    input  logic [6:0]       hex2,
    input  logic [6:0]       hex3,
    input  logic             clr_fault,
    output logic [2:0]       phase,
    output logic [6:0]       count_a,
    output logic [6:0]       count_b,
    output logic             count_valid,
    output logic             fault_conflict,
    output logic             fault_seq,
    output logic             fault_illegal,
    output logic             fault_timeout,
    output logic             fault_any,
    output logic [CNT_W-1:0] phase_changes
);

    localparam int TMR_W = (MAX_PHASE_CYCLES > 2) ? $clog2(MAX_PHASE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_AG    = 3'd1,
        S_AY    = 3'd2,
        S_BG    = 3'd3,
        S_BY    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // Returns {legal, digit} for an active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [4:0] seg_dec(input logic [6:0] s);
        case (s)
            7'b1000000: seg_dec = {1'b1, 4'd0};
            7'b1111001: seg_dec = {1'b1, 4'd1};
            7'b0100100: seg_dec = {1'b1, 4'd2};
            7'b0110000: seg_dec = {1'b1, 4'd3};
            7'b0011001: seg_dec = {1'b1, 4'd4};
            7'b0010010: seg_dec = {1'b1, 4'd5};
            7'b0000010: seg_dec = {1'b1, 4'd6};
            7'b1111000: seg_dec = {1'b1, 4'd7};
            7'b0000000: seg_dec = {1'b1, 4'd8};
            7'b0010000: seg_dec = {1'b1, 4'd9};
            default:    seg_dec = 5'd0;
        endcase
    endfunction

    // Stage-1 sample registers; r_primed masks the cleared contents right after reset.
    logic [2:0] r_street_a, r_street_b;
    logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3;
    logic       r_clr;
    logic       r_primed;

    // Stage-2 state
    state_t          r_state, w_state_nx;
    logic [TMR_W-1:0] r_timer, w_timer_nx;
    logic [CNT_W-1:0] r_pc, w_pc_nx;
    logic            r_armed, w_armed_nx;
    logic            r_f_conf, r_f_seq, r_f_ill, r_f_tmo;
    logic            w_f_conf_nx, w_f_seq_nx, w_f_ill_nx, w_f_tmo_nx;
    logic [6:0]      r_count_a, r_count_b;
    logic            r_count_valid;

    // Decode and check signals
    logic [4:0] w_d0, w_d1, w_d2, w_d3;
    logic       w_digits_ok;
    logic [6:0] w_cnt_a, w_cnt_b;
    logic       w_a_red, w_a_yel, w_a_grn, w_b_red, w_b_yel, w_b_grn;
    logic       w_light_bad, w_conflict;
    state_t     w_pair, w_succ;
    logic       w_pair_valid, w_in_phase, w_advance, w_stay, w_seq_bad, w_tmo, w_cnt_bad;
    logic       w_new_conf, w_new_seq, w_new_ill, w_new_tmo, w_new_any;

    // Register every input once before any decoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_street_a <= '0;
            r_street_b <= '0;
            r_hex0     <= '0;
            r_hex1     <= '0;
            r_hex2     <= '0;
            r_hex3     <= '0;
            r_clr      <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            r_street_a <= street_a;
            r_street_b <= street_b;
            r_hex0     <= hex0;
            r_hex1     <= hex1;
            r_hex2     <= hex2;
            r_hex3     <= hex3;
            r_clr      <= clr_fault;
            r_primed   <= 1'b1;
        end
    end

    // Decode digits and classify the light pair from the sampled inputs.
    always_comb begin
        w_d0        = seg_dec(r_hex0);
        w_d1        = seg_dec(r_hex1);
        w_d2        = seg_dec(r_hex2);
        w_d3        = seg_dec(r_hex3);
        w_digits_ok = w_d0[4] & w_d1[4] & w_d2[4] & w_d3[4];
        w_cnt_a     = 7'(w_d1[3:0]) * 7'd10 + 7'(w_d0[3:0]);
        w_cnt_b     = 7'(w_d3[3:0]) * 7'd10 + 7'(w_d2[3:0]);

        w_a_red = (r_street_a == 3'b100);
        w_a_yel = (r_street_a == 3'b010);
        w_a_grn = (r_street_a == 3'b001);
        w_b_red = (r_street_b == 3'b100);
        w_b_yel = (r_street_b == 3'b010);
        w_b_grn = (r_street_b == 3'b001);

        w_light_bad = !(w_a_red | w_a_yel | w_a_grn) || !(w_b_red | w_b_yel | w_b_grn);
        w_conflict  = !w_a_red && !w_b_red;

        // S_SYNC here stands for "no phase pair" (all-red or faulty lights).
        w_pair = S_SYNC;
        if (w_a_grn && w_b_red) w_pair = S_AG;
        if (w_a_yel && w_b_red) w_pair = S_AY;
        if (w_a_red && w_b_grn) w_pair = S_BG;
        if (w_a_red && w_b_yel) w_pair = S_BY;
        w_pair_valid = (w_pair != S_SYNC);

        case (r_state)
            S_AG:    w_succ = S_AY;
            S_AY:    w_succ = S_BG;
            S_BG:    w_succ = S_BY;
            S_BY:    w_succ = S_AG;
            default: w_succ = S_SYNC;
        endcase
    end

    // Sequence, timeout and countdown checks feeding the fault flags.
    always_comb begin
        w_in_phase = (r_state == S_AG) || (r_state == S_AY) ||
                     (r_state == S_BG) || (r_state == S_BY);
        w_advance  = w_in_phase && w_pair_valid && (w_pair == w_succ);
        w_stay     = w_in_phase && !w_advance;
        w_seq_bad  = w_in_phase && w_pair_valid && (w_pair != r_state) && !w_advance;
        w_tmo      = w_stay && (r_timer >= TMR_LAST);
`ifdef TLM_COUNT_CHECK_EN
        w_cnt_bad  = w_stay && r_armed && w_digits_ok &&
                     !(((w_cnt_a == r_count_a) || (w_cnt_a + 7'd1 == r_count_a)) &&
                       ((w_cnt_b == r_count_b) || (w_cnt_b + 7'd1 == r_count_b)));
`else
        w_cnt_bad  = 1'b0;
`endif
        w_new_conf = w_conflict;
        w_new_ill  = w_light_bad || !w_digits_ok;
        w_new_seq  = w_seq_bad || w_cnt_bad;
        w_new_tmo  = w_tmo;
        w_new_any  = w_new_conf | w_new_ill | w_new_seq | w_new_tmo;
    end

    // Next-state logic: clear beats faults, faults beat phase tracking.
    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_pc_nx     = r_pc;
        w_armed_nx  = r_armed;
        w_f_conf_nx = r_f_conf | w_new_conf;
        w_f_seq_nx  = r_f_seq  | w_new_seq;
        w_f_ill_nx  = r_f_ill  | w_new_ill;
        w_f_tmo_nx  = r_f_tmo  | w_new_tmo;
        if (r_clr) begin
            w_state_nx  = S_SYNC;
            w_timer_nx  = '0;
            w_armed_nx  = 1'b0;
            w_f_conf_nx = 1'b0;
            w_f_seq_nx  = 1'b0;
            w_f_ill_nx  = 1'b0;
            w_f_tmo_nx  = 1'b0;
        end else if (w_new_any || r_state == S_FAULT) begin
            w_state_nx = S_FAULT;
            w_timer_nx = '0;
            w_armed_nx = 1'b0;
        end else if (r_state == S_SYNC) begin
            if (w_pair_valid) begin
                w_state_nx = w_pair;
                w_timer_nx = '0;
                w_armed_nx = w_digits_ok;
            end
        end else if (w_advance) begin
            w_state_nx = w_pair;
            w_timer_nx = '0;
            w_pc_nx    = (&r_pc) ? r_pc : r_pc + 1'b1;
            w_armed_nx = w_digits_ok;
        end else begin
            w_timer_nx = r_timer + 1'b1;
            w_armed_nx = r_armed | w_digits_ok;
        end
    end

    // Stage-2 registers: FSM, timer, counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_SYNC;
            r_timer       <= '0;
            r_pc          <= '0;
            r_armed       <= 1'b0;
            r_f_conf      <= 1'b0;
            r_f_seq       <= 1'b0;
            r_f_ill       <= 1'b0;
            r_f_tmo       <= 1'b0;
            r_count_a     <= '0;
            r_count_b     <= '0;
            r_count_valid <= 1'b0;
        end else if (r_primed) begin
            r_state       <= w_state_nx;
            r_timer       <= w_timer_nx;
            r_pc          <= w_pc_nx;
            r_armed       <= w_armed_nx;
            r_f_conf      <= w_f_conf_nx;
            r_f_seq       <= w_f_seq_nx;
            r_f_ill       <= w_f_ill_nx;
            r_f_tmo       <= w_f_tmo_nx;
            r_count_valid <= w_digits_ok;
            if (w_digits_ok) begin
                r_count_a <= w_cnt_a;
                r_count_b <= w_cnt_b;
            end
        end
    end

    assign phase          = r_state;
    assign count_a        = r_count_a;
    assign count_b        = r_count_b;
    assign count_valid    = r_count_valid;
    assign fault_conflict = r_f_conf;
    assign fault_seq      = r_f_seq;
    assign fault_illegal  = r_f_ill;
    assign fault_timeout  = r_f_tmo;
    assign fault_any      = r_f_conf | r_f_seq | r_f_ill | r_f_tmo;
    assign phase_changes  = r_pc;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] street_a, street_b;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       clr_fault;
    logic [2:0] phase;
    logic [6:0] count_a, count_b;
    logic       count_valid;
    logic       fault_conflict, fault_seq, fault_illegal, fault_timeout, fault_any;
    logic [2:0] phase_changes;

    int n_vec = 0;
    int n_err = 0;
    int exp_seq;
    int exp_phase;

    always #5 clk = ~clk;

    traffic_light_monitor #(.MAX_PHASE_CYCLES(20), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .street_a(street_a), .street_b(street_b),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .clr_fault(clr_fault),
        .phase(phase), .count_a(count_a), .count_b(count_b), .count_valid(count_valid),
        .fault_conflict(fault_conflict), .fault_seq(fault_seq),
        .fault_illegal(fault_illegal), .fault_timeout(fault_timeout),
        .fault_any(fault_any), .phase_changes(phase_changes)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            default: seg = 7'b0010000;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] la, input logic [2:0] lb, input int ca, input int cb);
        street_a = la;
        street_b = lb;
        hex1 = seg(ca / 10);
        hex0 = seg(ca % 10);
        hex3 = seg(cb / 10);
        hex2 = seg(cb % 10);
    endtask

    task automatic clear();
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0;
        clr_fault = 1'b0;
        drive(L_R, L_R, 0, 0);
        step(3);
        chk("rst_phase", phase, 0);
        chk("rst_any", fault_any, 0);
        chk("rst_valid", count_valid, 0);
        chk("rst_pc", phase_changes, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_phase", phase, 0);
        chk("idle_valid", count_valid, 1);
        chk("idle_any", fault_any, 0);

        // normal cycle AG AY BG BY AG
        drive(L_G, L_R, 5, 0);  step(2);
        chk("seq_ag", phase, 1);
        chk("seq_cnt_a", count_a, 5);
        drive(L_Y, L_R, 4, 0);  step(2);
        chk("seq_ay", phase, 2);
        drive(L_R, L_G, 0, 12); step(2);
        chk("seq_bg", phase, 3);
        chk("seq_cnt_b", count_b, 12);
        drive(L_R, L_Y, 0, 3);  step(2);
        chk("seq_by", phase, 4);
        drive(L_G, L_R, 9, 0);  step(2);
        chk("seq_ag2", phase, 1);
        chk("seq_pc", phase_changes, 4);
        chk("seq_any", fault_any, 0);

        // conflict, then clear with legal lights
        drive(L_G, L_G, 9, 0);  step(2);
        chk("conf_flag", fault_conflict, 1);
        chk("conf_phase", phase, 5);
        chk("conf_seq", fault_seq, 0);
        chk("conf_any", fault_any, 1);
        drive(L_G, L_R, 9, 0);
        clear();
        chk("clr_phase", phase, 0);
        chk("clr_conf", fault_conflict, 0);
        chk("clr_any", fault_any, 0);
        step(1);
        chk("resync_phase", phase, 1);
        chk("clr_pc_kept", phase_changes, 4);

        // AG -> BG jump
        drive(L_R, L_G, 0, 9);  step(2);
        chk("jump_seq", fault_seq, 1);
        chk("jump_phase", phase, 5);
        chk("jump_conf", fault_conflict, 0);
        clear();
        step(1);
        chk("jump_resync", phase, 3);

        // BY AG AY, all-red, BG; counter saturates at 7
        drive(L_R, L_Y, 0, 5);  step(2);
        chk("ar_by", phase, 4);
        drive(L_G, L_R, 5, 0);  step(2);
        drive(L_Y, L_R, 2, 0);  step(2);
        chk("ar_ay", phase, 2);
        drive(L_R, L_R, 0, 0);  step(2);
        chk("ar_hold", phase, 2);
        chk("ar_any", fault_any, 0);
        drive(L_R, L_G, 0, 9);  step(2);
        chk("ar_bg", phase, 3);
        chk("ar_any2", fault_any, 0);
        chk("pc_sat", phase_changes, 7);

        // illegal light code
        drive(3'b011, L_R, 0, 0); step(2);
        chk("ill_light", fault_illegal, 1);
        chk("ill_phase", phase, 5);
        chk("ill_conf", fault_conflict, 0);
        chk("ill_valid", count_valid, 1);
        drive(L_R, L_R, 53, 0);
        clear();
        chk("dec_phase", phase, 0);
        chk("dec_53", count_a, 53);
        chk("dec_valid", count_valid, 1);
        chk("dec_any", fault_any, 0);

        // undecodable digit
        hex0 = 7'b1111111;      step(2);
        chk("bad_seg_ill", fault_illegal, 1);
        chk("bad_seg_valid", count_valid, 0);
        chk("bad_seg_hold", count_a, 53);
        chk("bad_seg_phase", phase, 5);
        drive(L_R, L_R, 0, 0);
        clear();
        chk("bad_seg_clr", fault_any, 0);

        // timeout at 20 cycles in AG
        drive(L_G, L_R, 9, 0);  step(21);
        chk("tmo_before", fault_timeout, 0);
        chk("tmo_before_ph", phase, 1);
        step(1);
        chk("tmo_flag", fault_timeout, 1);
        chk("tmo_phase", phase, 5);
        chk("tmo_conf", fault_conflict, 0);
        drive(L_R, L_R, 0, 0);
        clear();

        // countdown 09 -> 08 -> 06 within AG
        drive(L_G, L_R, 9, 0);  step(2);
        chk("cd_ag", phase, 1);
        drive(L_G, L_R, 8, 0);  step(2);
        chk("cd_step1", fault_seq, 0);
        drive(L_G, L_R, 6, 0);  step(2);
`ifdef TLM_COUNT_CHECK_EN
        exp_seq = 1;
        exp_phase = 5;
`else
        exp_seq = 0;
        exp_phase = 1;
`endif
        chk("cd_skip_seq", fault_seq, exp_seq);
        chk("cd_skip_phase", phase, exp_phase);
        chk("cd_cnt", count_a, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
